// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix BRAM readers.
package matrix_pkg;

   localparam int MATRIX_SLOTS = 8;
   localparam int BLOCK_SIZE   = 1152;
   localparam int ADDR_WIDTH   = 14;
   localparam int DATA_WIDTH   = 32;
   localparam int DIM_WIDTH    = 6;
   localparam int ID_WIDTH     = $clog2(MATRIX_SLOTS);
   localparam int TOTAL_WIDTH  = 2 * DIM_WIDTH;

   typedef enum logic [2:0] {
      RD_IDLE   = 3'd0,
      RD_CHECK  = 3'd1,
      RD_ERR    = 3'd2,
      RD_STREAM = 3'd3,
      RD_DRAIN  = 3'd4,
      RD_DONE   = 3'd5
   } rd_state_t;

endpackage

// File: rtl/matrix_address_getter.sv
// Base word address of a matrix slot: slots are packed back to back, BLOCK_SIZE words each.
module matrix_address_getter
   import matrix_pkg::*;
(
   input  logic [ID_WIDTH-1:0]   matrix_id,
   output logic [ADDR_WIDTH-1:0] base_addr
);

   // Slot 7 ends at 8*1152-1 = 9215, so the product always fits ADDR_WIDTH.
   always_comb begin
      base_addr = ADDR_WIDTH'(matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);
   end

endmodule

// File: rtl/matrix_stream_fifo2.sv
// Two-entry FIFO holding {last, data} between the BRAM read port and the output stream.
// Push and pop may happen in the same cycle; the caller guarantees no push when full
// and no pop when empty.
module matrix_stream_fifo2 #(
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;

   // Next storage contents, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   // Storage and pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/matrix_block_reader.sv
// Streams one stored matrix out of the shared matrix BRAM in row-major order
// on a valid/ready stream with full backpressure.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   RD_IDLE   | waiting for start; id/dims latched when start arrives
//   RD_CHECK  | validate rows*cols against the slot size
//   RD_ERR    | one-cycle error pulse, back to idle
//   RD_STREAM | issuing BRAM reads as credit allows
//   RD_DRAIN  | all reads issued, waiting for the last element handshake
//   RD_DONE   | one-cycle done pulse, back to idle
module matrix_block_reader
   import matrix_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ID_WIDTH-1:0]   matrix_id,
   input  logic [DIM_WIDTH-1:0]  rows,
   input  logic [DIM_WIDTH-1:0]  cols,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  bram_rd_en,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [DATA_WIDTH-1:0] bram_rd_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   rd_state_t               state_q, state_d;
   logic [ID_WIDTH-1:0]     id_q, id_d;
   logic [DIM_WIDTH-1:0]    rows_q, rows_d;
   logic [DIM_WIDTH-1:0]    cols_q, cols_d;
   logic [TOTAL_WIDTH-1:0]  rd_idx_q, rd_idx_d;
   logic                    inflight_q, inflight_d;
   logic                    inflight_last_q, inflight_last_d;

   logic [TOTAL_WIDTH-1:0]  total;
   logic                    dims_bad;
   logic                    is_last_idx;
   logic [ADDR_WIDTH-1:0]   base_addr;
   logic [2:0]              credit_used;
   logic                    credit_ok;
   logic                    rd_en;

   logic [DATA_WIDTH:0]     fifo_head;
   logic [1:0]              fifo_count;
   logic                    fifo_empty;
   logic                    fifo_pop;
   logic                    stream_phase;

   matrix_address_getter u_addr (
      .matrix_id (id_q),
      .base_addr (base_addr)
   );

   matrix_stream_fifo2 #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data ({inflight_last_q, bram_rd_data}),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

   // Dimension check and read bookkeeping derived from the latched request.
   always_comb begin
      total       = {{DIM_WIDTH{1'b0}}, rows_q} * {{DIM_WIDTH{1'b0}}, cols_q};
      dims_bad    = (rows_q == '0) || (cols_q == '0) ||
                    (total > TOTAL_WIDTH'(BLOCK_SIZE));
      is_last_idx = (rd_idx_q == total - TOTAL_WIDTH'(1));
   end

   // Output stream view of the FIFO; an element leaving this cycle frees its
   // credit immediately so a ready consumer sees back-to-back beats.
   always_comb begin
      stream_phase = (state_q == RD_STREAM) || (state_q == RD_DRAIN);
      fifo_empty   = (fifo_count == 2'd0);
      out_valid    = stream_phase && !fifo_empty;
      fifo_pop     = out_valid && out_ready;
      out_data     = out_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
      out_last     = out_valid ? fifo_head[DATA_WIDTH] : 1'b0;
      credit_used  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
      credit_ok    = (credit_used < 3'd2);
   end

   // Next-state, read issue and status pulses.
   always_comb begin
      state_d         = state_q;
      id_d            = id_q;
      rows_d          = rows_q;
      cols_d          = cols_q;
      rd_idx_d        = rd_idx_q;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      rd_en           = 1'b0;
      busy            = (state_q != RD_IDLE);
      done            = 1'b0;
      error           = 1'b0;

      case (state_q)
         RD_IDLE: begin
            if (start) begin
               state_d  = RD_CHECK;
               id_d     = matrix_id;
               rows_d   = rows;
               cols_d   = cols;
               rd_idx_d = '0;
            end
         end
         RD_CHECK: begin
            state_d = dims_bad ? RD_ERR : RD_STREAM;
         end
         RD_ERR: begin
            error   = 1'b1;
            state_d = RD_IDLE;
         end
         RD_STREAM: begin
            if (credit_ok) begin
               rd_en           = 1'b1;
               rd_idx_d        = rd_idx_q + TOTAL_WIDTH'(1);
               inflight_d      = 1'b1;
               inflight_last_d = is_last_idx;
               if (is_last_idx) begin
                  state_d = RD_DRAIN;
               end
            end
         end
         RD_DRAIN: begin
            if (fifo_pop && fifo_head[DATA_WIDTH]) begin
               state_d = RD_DONE;
            end
         end
         RD_DONE: begin
            done    = 1'b1;
            state_d = RD_IDLE;
         end
         default: begin
            state_d = RD_IDLE;
         end
      endcase
   end

   // Read port drives zero whenever no read is being issued.
   always_comb begin
      bram_rd_en = rd_en;
      bram_addr  = rd_en ? (base_addr + ADDR_WIDTH'(rd_idx_q)) : '0;
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= RD_IDLE;
         id_q            <= '0;
         rows_q          <= '0;
         cols_q          <= '0;
         rd_idx_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         id_q            <= id_d;
         rows_q          <= rows_d;
         cols_q          <= cols_d;
         rd_idx_q        <= rd_idx_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
      end
   end

endmodule
